// File: rtl/cv32e40p_apu_disp_multi_if.sv
// APU interconnect handshake between the EX-stage dispatcher and the APU.
interface cv32e40p_apu_disp_multi_if;
  logic apu_req_o;
  logic apu_gnt_i;
  logic apu_rvalid_i;

  // Dispatcher side: raises requests, observes grant and response valid.
  modport master (
    output apu_req_o,
    input  apu_gnt_i,
    input  apu_rvalid_i
  );

  // APU side: observes requests, returns grant and response valid.
  modport slave (
    input  apu_req_o,
    output apu_gnt_i,
    output apu_rvalid_i
  );
endinterface

// File: rtl/cv32e40p_apu_disp_multi.sv
// Multi-outstanding APU dispatcher: in-order scoreboard of in-flight
// destinations, RAW/WAW hazard flags to ID, and result tagging for EX.
module cv32e40p_apu_disp_multi #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NREAD  = 3,
  parameter int unsigned NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     enable_i,
  input  logic [1:0]               apu_lat_i,
  input  logic [ADDR_W-1:0]        apu_waddr_i,

  input  logic                     is_decoding_i,
  input  logic [NREAD*ADDR_W-1:0]  read_regs_i,
  input  logic [NREAD-1:0]         read_regs_valid_i,
  input  logic [NWRITE*ADDR_W-1:0] write_regs_i,
  input  logic [NWRITE-1:0]        write_regs_valid_i,
  output logic                     read_dep_o,
  output logic                     write_dep_o,

  cv32e40p_apu_disp_multi_if.master apu,

  output logic                     apu_valid_o,
  output logic [ADDR_W-1:0]        apu_waddr_o,
  output logic                     apu_singlecycle_o,
  output logic                     apu_multicycle_o,

  output logic                     stall_o,
  output logic                     active_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                     perf_cont_o,
  output logic                     perf_type_o,
  output logic                     err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [1:0]        lat;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  logic               full;
  logic               empty;
  logic               self_dep;
  logic               req;
  logic               push;
  logic               pop;
  logic [DEPTH-1:0]   entry_valid;
  logic               read_hit;
  logic               write_hit;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Mark which slots hold in-flight requests (window of count_q from the head).
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q);
    end
  end

  // Match EX destination and ID sources/destinations against in-flight entries.
  always_comb begin
    self_dep  = 1'b0;
    read_hit  = 1'b0;
    write_hit = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (entry_valid[e]) begin
        if (fifo_q[e].waddr == apu_waddr_i) self_dep = 1'b1;
        for (int r = 0; r < NREAD; r++) begin
          if (read_regs_valid_i[r] &&
              (read_regs_i[r*ADDR_W +: ADDR_W] == fifo_q[e].waddr)) begin
            read_hit = 1'b1;
          end
        end
        for (int w = 0; w < NWRITE; w++) begin
          if (write_regs_valid_i[w] &&
              (write_regs_i[w*ADDR_W +: ADDR_W] == fifo_q[e].waddr)) begin
            write_hit = 1'b1;
          end
        end
      end
    end
  end

  // Same-register requests wait so results retire in issue order.
  assign req  = enable_i & ~full & ~self_dep;
  assign push = req & apu.apu_gnt_i;
  assign pop  = apu.apu_rvalid_i & ~empty;

  assign apu.apu_req_o = req;
  assign read_dep_o    = is_decoding_i & read_hit;
  assign write_dep_o   = is_decoding_i & write_hit;
  assign stall_o       = enable_i & ~push;
  assign perf_cont_o   = req & ~apu.apu_gnt_i;
  assign perf_type_o   = enable_i & full;
  assign active_o      = ~empty;
  assign occupancy_o   = count_q;
  assign err_o         = err_q;

  // Present the FIFO head as the returning result tag during a pop.
  always_comb begin
    apu_valid_o       = 1'b0;
    apu_waddr_o       = '0;
    apu_singlecycle_o = 1'b0;
    apu_multicycle_o  = 1'b0;
    if (pop) begin
      apu_valid_o       = 1'b1;
      apu_waddr_o       = fifo_q[rd_ptr_q].waddr;
      apu_singlecycle_o = (fifo_q[rd_ptr_q].lat == 2'd0);
      apu_multicycle_o  = fifo_q[rd_ptr_q].lat[1];
    end
  end

  // Scoreboard storage, pointers, occupancy and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{waddr: apu_waddr_i, lat: apu_lat_i};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (apu.apu_rvalid_i && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_disp_multi.sv
// Directed bench for the APU dispatcher with a queue-based reference model.
module tb_cv32e40p_apu_disp_multi;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NREAD  = 3;
  localparam int unsigned NWRITE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_i = 1'b0;
  logic [1:0] apu_lat_i = '0;
  logic [ADDR_W-1:0] apu_waddr_i = '0;
  logic is_decoding_i = 1'b0;
  logic [NREAD*ADDR_W-1:0] read_regs_i = '0;
  logic [NREAD-1:0] read_regs_valid_i = '0;
  logic [NWRITE*ADDR_W-1:0] write_regs_i = '0;
  logic [NWRITE-1:0] write_regs_valid_i = '0;
  logic read_dep_o, write_dep_o;
  logic apu_valid_o, apu_singlecycle_o, apu_multicycle_o;
  logic [ADDR_W-1:0] apu_waddr_o;
  logic stall_o, active_o, perf_cont_o, perf_type_o, err_o;
  logic [2:0] occupancy_o;

  cv32e40p_apu_disp_multi_if apu_if ();

  cv32e40p_apu_disp_multi #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .NWRITE(NWRITE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enable_i(enable_i), .apu_lat_i(apu_lat_i), .apu_waddr_i(apu_waddr_i),
    .is_decoding_i(is_decoding_i),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
    .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
    .read_dep_o(read_dep_o), .write_dep_o(write_dep_o),
    .apu(apu_if),
    .apu_valid_o(apu_valid_o), .apu_waddr_o(apu_waddr_o),
    .apu_singlecycle_o(apu_singlecycle_o), .apu_multicycle_o(apu_multicycle_o),
    .stall_o(stall_o), .active_o(active_o), .occupancy_o(occupancy_o),
    .perf_cont_o(perf_cont_o), .perf_type_o(perf_type_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: in-flight requests as a plain queue in issue order.
  typedef struct {
    int waddr;
    int lat;
  } ent_t;
  ent_t q[$];
  bit   m_err;

  function automatic bit in_flight(input int a);
    foreach (q[i]) if (q[i].waddr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_req();
    return enable_i && (q.size() < DEPTH) && !in_flight(int'(apu_waddr_i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      bit do_push, do_pop;
      ent_t e;
      do_push = m_req() && apu_if.apu_gnt_i;
      do_pop  = apu_if.apu_rvalid_i && (q.size() > 0);
      if (apu_if.apu_rvalid_i && q.size() == 0) m_err = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.waddr = int'(apu_waddr_i);
        e.lat   = int'(apu_lat_i);
        q.push_back(e);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    bit req, pop, rd, wd;
    int hw, hl;
    req = m_req();
    pop = apu_if.apu_rvalid_i && (q.size() > 0);
    hw  = pop ? q[0].waddr : 0;
    hl  = pop ? q[0].lat : 0;
    rd = 1'b0;
    wd = 1'b0;
    for (int r = 0; r < NREAD; r++)
      if (read_regs_valid_i[r] && in_flight(int'(read_regs_i[r*ADDR_W +: ADDR_W]))) rd = 1'b1;
    for (int w = 0; w < NWRITE; w++)
      if (write_regs_valid_i[w] && in_flight(int'(write_regs_i[w*ADDR_W +: ADDR_W]))) wd = 1'b1;
    check("m_req", int'(apu_if.apu_req_o), int'(req));
    check("m_valid", int'(apu_valid_o), int'(pop));
    check("m_waddr", int'(apu_waddr_o), hw);
    check("m_single", int'(apu_singlecycle_o), int'(pop && hl == 0));
    check("m_multi", int'(apu_multicycle_o), int'(pop && hl >= 2));
    check("m_stall", int'(stall_o), int'(enable_i && !(req && apu_if.apu_gnt_i)));
    check("m_cont", int'(perf_cont_o), int'(req && !apu_if.apu_gnt_i));
    check("m_type", int'(perf_type_o), int'(enable_i && q.size() == DEPTH));
    check("m_active", int'(active_o), int'(q.size() > 0));
    check("m_occ", int'(occupancy_o), q.size());
    check("m_err", int'(err_o), int'(m_err));
    check("m_rdep", int'(read_dep_o), int'(is_decoding_i && rd));
    check("m_wdep", int'(write_dep_o), int'(is_decoding_i && wd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input int wa, input int lat, input bit gnt, input bit rv);
    enable_i            = en;
    apu_waddr_i         = ADDR_W'(wa);
    apu_lat_i           = 2'(lat);
    apu_if.apu_gnt_i    = gnt;
    apu_if.apu_rvalid_i = rv;
  endtask

  initial begin
    apu_if.apu_gnt_i    = 1'b0;
    apu_if.apu_rvalid_i = 1'b0;
    #2;
    check("rst_occ", int'(occupancy_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_valid", int'(apu_valid_o), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single op: issue waddr 5, response two cycles later.
    drive(1, 5, 0, 1, 0); #2;
    check("single_req", int'(apu_if.apu_req_o), 1);
    check("single_stall", int'(stall_o), 0);
    step();
    drive(0, 0, 0, 0, 0); #2;
    check("single_occ1", int'(occupancy_o), 1);
    step();
    drive(0, 0, 0, 0, 1); #2;
    check("single_valid", int'(apu_valid_o), 1);
    check("single_waddr", int'(apu_waddr_o), 5);
    check("single_sc", int'(apu_singlecycle_o), 1);
    check("single_occ2", int'(occupancy_o), 1);
    step();
    drive(0, 0, 0, 0, 0); #2;
    check("single_occ3", int'(occupancy_o), 0);
    step();

    // Fill to DEPTH, then a blocked fifth request.
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, k % 4, 1, 0);
      step();
    end
    drive(1, 9, 0, 1, 1); #2;
    check("fill_occ", int'(occupancy_o), 4);
    check("fill_req", int'(apu_if.apu_req_o), 0);
    check("fill_stall", int'(stall_o), 1);
    check("fill_type", int'(perf_type_o), 1);
    check("fill_pop_waddr", int'(apu_waddr_o), 1);
    step();
    drive(1, 9, 0, 1, 0); #2;
    check("fill_occ3", int'(occupancy_o), 3);
    check("fill_req5", int'(apu_if.apu_req_o), 1);
    step();
    drive(0, 0, 0, 0, 1); #2;
    check("fill_head2", int'(apu_waddr_o), 2);
    check("fill_multi2", int'(apu_multicycle_o), 1);
    step();
    for (int k = 0; k < 3; k++) step();
    drive(0, 0, 0, 0, 0); #2;
    check("fill_drained", int'(occupancy_o), 0);
    step();

    // Stream ten ops with a constant two-cycle response across pointer wrap.
    for (int c = 0; c < 12; c++) begin
      drive(c < 10, 10 + c, 1, 1, c >= 2); #2;
      if (c >= 2) check("wrap_waddr", int'(apu_waddr_o), 10 + c - 2);
      check("wrap_occ_le4", int'(occupancy_o <= 3'd4), 1);
      step();
    end
    drive(0, 0, 0, 0, 0); #2;
    check("wrap_empty", int'(occupancy_o), 0);
    step();

    // Dependencies against in-flight waddr 7.
    drive(1, 7, 2, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    is_decoding_i = 1'b1;
    read_regs_i = {6'd3, 6'd7, 6'd1};
    read_regs_valid_i = 3'b010; #2;
    check("dep_raw", int'(read_dep_o), 1);
    step();
    read_regs_valid_i = 3'b000; #2;
    check("dep_raw_inv", int'(read_dep_o), 0);
    step();
    write_regs_i = {6'd2, 6'd7};
    write_regs_valid_i = 2'b01; #2;
    check("dep_waw", int'(write_dep_o), 1);
    step();
    drive(1, 7, 0, 1, 0); #2;
    check("dep_self_req", int'(apu_if.apu_req_o), 0);
    check("dep_self_stall", int'(stall_o), 1);
    step();
    drive(0, 0, 0, 0, 1);
    read_regs_valid_i = 3'b010; #2;
    check("dep_pop_still", int'(read_dep_o), 1);
    step();
    drive(0, 0, 0, 0, 0);
    is_decoding_i = 1'b0;
    read_regs_valid_i = '0;
    write_regs_valid_i = '0;
    step();

    // Contention for three cycles, then push and pop together.
    for (int k = 0; k < 3; k++) begin
      drive(1, 20, 3, 0, 0); #2;
      check("cont_perf", int'(perf_cont_o), 1);
      check("cont_stall", int'(stall_o), 1);
      step();
    end
    drive(1, 20, 3, 1, 0); step();
    drive(1, 21, 0, 1, 0); step();
    drive(1, 22, 1, 1, 1); #2;
    check("pp_occ_before", int'(occupancy_o), 2);
    check("pp_head", int'(apu_waddr_o), 20);
    step();
    drive(0, 0, 0, 0, 0); #2;
    check("pp_occ_after", int'(occupancy_o), 2);
    step();
    drive(0, 0, 0, 0, 1); step(); step();
    drive(0, 0, 0, 0, 0); #2;
    check("pp_drained", int'(occupancy_o), 0);
    step();

    // Response with nothing in flight, then reset with requests outstanding.
    drive(0, 0, 0, 0, 1); #2;
    check("err_valid", int'(apu_valid_o), 0);
    step();
    drive(0, 0, 0, 0, 0); #2;
    check("err_set", int'(err_o), 1);
    step(); #2;
    check("err_sticky", int'(err_o), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 30 + k, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0); #1;
    check("rst_mid_occ3", int'(occupancy_o), 3);
    rst_n = 1'b0; #1;
    check("rst_mid_occ", int'(occupancy_o), 0);
    check("rst_mid_err", int'(err_o), 0);
    step();
    rst_n = 1'b1;
    step();
    drive(0, 0, 0, 0, 1); #2;
    check("late_rsp_valid", int'(apu_valid_o), 0);
    step();
    drive(0, 0, 0, 0, 0); #2;
    check("late_rsp_err", int'(err_o), 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cv32e40p_apu_disp_multi.md
Name: cv32e40p_apu_disp_multi

Overview:
- Parametrised APU dispatcher for the EX stage. It replaces the fixed no-APU tie-offs with a real offload path that supports up to DEPTH outstanding requests.
- It tracks the destination register of each in-flight request in an in-order scoreboard FIFO.
- It flags read-after-write and write-after-write hazards to ID, and stalls EX when the FIFO is full or a hazard exists.
- It tags each returning result with its destination address and latency class, so EX can route it to the ALU or LSU write port.

Parameters:
DEPTH, 4, maximum outstanding APU requests; power of two, >= 2
ADDR_W, 6, register address width
NREAD, 3, number of source-register dependency ports
NWRITE, 2, number of destination-register dependency ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  APU instruction present in EX
apu_lat_i  in  2  latency class: 0 = single, 1 = two-cycle, 2/3 = multicycle
apu_waddr_i  in  ADDR_W  destination register of the EX instruction
is_decoding_i  in  1  ID holds a valid instruction (qualifies dependency outputs)
read_regs_i  in  NREAD*ADDR_W  ID source registers
read_regs_valid_i  in  NREAD  per-source valid
write_regs_i  in  NWRITE*ADDR_W  ID destination registers
write_regs_valid_i  in  NWRITE  per-destination valid
read_dep_o  out  1  RAW hazard with an in-flight destination
write_dep_o  out  1  WAW hazard with an in-flight destination
apu_req_o  out  1  request to APU interconnect
apu_gnt_i  in  1  grant
apu_rvalid_i  in  1  response valid
apu_valid_o  out  1  result valid this cycle (= accepted rvalid)
apu_waddr_o  out  ADDR_W  destination of the returning result
apu_singlecycle_o  out  1  returning result is latency class 0
apu_multicycle_o  out  1  returning result is latency class 2/3
stall_o  out  1  EX must hold the APU instruction
active_o  out  1  at least one request in flight
occupancy_o  out  $clog2(DEPTH+1)  in-flight count
perf_cont_o  out  1  request pending without grant (contention)
perf_type_o  out  1  stall caused by a full FIFO
err_o  out  1  sticky: rvalid received with no request in flight

Behaviour:
- Reset values: FIFO empty, occupancy_o = 0, err_o = 0. All outputs 0 except apu_waddr_o = 0.
- Entry contents: {waddr, lat}. Read/write pointers are log2(DEPTH) bits, wrap naturally; count is tracked separately.
- full = (count == DEPTH); empty = (count == 0).
- Request rule: apu_req_o = enable_i & ~full & ~self_dep.
  - self_dep = apu_waddr_i matches any in-flight waddr.
  - This enforces in-order writeback of the same register.
- Push: on apu_req_o & apu_gnt_i, write {apu_waddr_i, apu_lat_i} at the write pointer at the next edge.
- Pop: on apu_rvalid_i & ~empty, the head is presented combinationally the same cycle:
  - apu_valid_o = 1
  - apu_waddr_o = head.waddr
  - apu_singlecycle_o = (head.lat == 0)
  - apu_multicycle_o = head.lat[1]
  - The read pointer advances at the next edge.
- Zero-latency responses: rvalid in the same cycle as the grant for an empty FIFO is NOT bypassed. The APU must respond at least one cycle after the grant.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push is still blocked when full at the start of the cycle, even if a pop occurs that cycle; no full-bypass.
- rvalid while empty: ignored, apu_valid_o = 0, err_o set and held until reset.
- Dependency outputs:
  - read_dep_o = is_decoding_i & OR over valid read ports and all valid FIFO entries of (read_reg == entry.waddr).
  - write_dep_o is the same over the write ports.
  - A FIFO entry popped in the current cycle still counts as a dependency.
- stall_o = enable_i & ~(apu_req_o & apu_gnt_i).
- perf_cont_o = apu_req_o & ~apu_gnt_i.
- perf_type_o = enable_i & full.
- active_o = ~empty; occupancy_o = count.
- Reset mid-operation: everything clears asynchronously. In-flight responses arriving after reset are treated as rvalid-while-empty, so err_o is set.

Test Plan:
- Single op: enable_i = 1, waddr = 5, lat = 0, gnt in cycle 0, rvalid in cycle 2 -> apu_req_o = 1 in cycle 0; occupancy 1 in cycles 1-2. In cycle 2: apu_valid_o = 1, apu_waddr_o = 5, singlecycle = 1. occupancy 0 in cycle 3.
- Fill: 4 granted ops with waddr 1..4 and no rvalid -> occupancy 4; a 5th enable gives apu_req_o = 0, stall_o = 1, perf_type_o = 1. One rvalid returns waddr 1, and the 5th op is granted in the following cycle.
- In-order wrap: 10 ops streamed with a constant 2-cycle response, DEPTH = 4 -> apu_waddr_o sequence matches issue order across pointer wrap; occupancy never exceeds 4.
- Dependencies: waddr 7 in flight, is_decoding_i = 1, read_regs[1] = 7 valid -> read_dep_o = 1. Same with valid = 0 -> 0. write_regs[0] = 7 -> write_dep_o = 1. EX enable with waddr 7 -> apu_req_o = 0.
- Contention and push/pop together: gnt held low for 3 cycles -> perf_cont_o = 1 and stall_o = 1 for 3 cycles. Then with occupancy 2, push and pop in the same cycle -> occupancy stays 2.
- Error and reset: rvalid with an empty FIFO -> apu_valid_o = 0, err_o = 1 sticky. Assert rst_n low with occupancy 3 -> occupancy_o = 0 and err_o = 0 immediately.
